// File: rtl/filter_input_sequencer.sv
// Sample sequencer in front of a FIR filter: emits an impulse or a buffered
// sample stream on each sample strobe, then flushes the filter taps with zeros.
module filter_input_sequencer #(
  parameter int                 DEPTH     = 4,
  parameter int                 FLUSH_LEN = 64,
  parameter logic signed [17:0] IMP_VAL   = 18'sd131071
) (
  input  logic               sys_clk,
  input  logic               reset,
  input  logic               sam_clk_en,
  input  logic               start,
  input  logic               mode_sel,
  input  logic               stop,
  input  logic signed [17:0] src_data,
  input  logic               src_valid,
  output logic               src_ready,
  output logic signed [17:0] x_in,
  output logic               x_valid,
  output logic               busy,
  output logic [7:0]         underflow_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FW = $clog2(FLUSH_LEN + 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);
  localparam logic [FW-1:0] FLUSH_END = FW'(FLUSH_LEN);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IMPULSE = 2'd1,
    ST_STREAM  = 2'd2,
    ST_FLUSH   = 2'd3
  } state_t;

  state_t             state_r, state_s;
  logic signed [17:0] fifo_mem_r [DEPTH];
  logic [AW-1:0]      wr_ptr_r, wr_ptr_s;
  logic [AW-1:0]      rd_ptr_r, rd_ptr_s;
  logic [AW:0]        count_r, count_s;
  logic               stop_pending_r, stop_pending_s;
  logic [FW-1:0]      flush_cnt_r, flush_cnt_s, flush_inc_s;
  logic signed [17:0] x_in_r, x_in_s;
  logic               x_valid_r, x_valid_s;
  logic               src_ready_r, src_ready_s;
  logic               busy_r, busy_s;
  logic [7:0]         underflow_cnt_r, underflow_cnt_s;
  logic               push_s, pop_s, fifo_empty_s;

  assign push_s       = src_valid && src_ready_r;
  assign fifo_empty_s = (count_r == {(AW + 1){1'b0}});
  assign flush_inc_s  = flush_cnt_r + FW'(1);

  // Next state, output sample, flush and underflow bookkeeping
  always_comb begin
    state_s         = state_r;
    stop_pending_s  = stop_pending_r;
    flush_cnt_s     = flush_cnt_r;
    x_in_s          = x_in_r;
    x_valid_s       = 1'b0;
    underflow_cnt_s = underflow_cnt_r;
    pop_s           = 1'b0;
    case (state_r)
      ST_IDLE: begin
        x_in_s = 18'sd0;
        if (start) begin
          state_s         = mode_sel ? ST_IMPULSE : ST_STREAM;
          underflow_cnt_s = 8'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_IMPULSE: begin
        if (sam_clk_en) begin
          x_in_s      = IMP_VAL;
          x_valid_s   = 1'b1;
          flush_cnt_s = {FW{1'b0}};
          state_s     = ST_FLUSH;
        end else begin
          state_s = ST_IMPULSE;
        end
      end
      ST_STREAM: begin
        if (stop) begin
          stop_pending_s = 1'b1;
        end else begin
          stop_pending_s = stop_pending_r;
        end
        if (sam_clk_en) begin
          x_valid_s = 1'b1;
          if (!fifo_empty_s) begin
            pop_s  = 1'b1;
            x_in_s = fifo_mem_r[rd_ptr_r];
          end else if (stop_pending_r) begin
            // This zero is the first of the flush sequence
            x_in_s      = 18'sd0;
            flush_cnt_s = FW'(1);
            state_s     = (FLUSH_LEN <= 1) ? ST_IDLE : ST_FLUSH;
          end else begin
            x_in_s = 18'sd0;
            if (underflow_cnt_r != 8'hFF) begin
              underflow_cnt_s = underflow_cnt_r + 8'd1;
            end else begin
              underflow_cnt_s = underflow_cnt_r;
            end
          end
        end else begin
          state_s = ST_STREAM;
        end
      end
      ST_FLUSH: begin
        if (sam_clk_en) begin
          x_in_s      = 18'sd0;
          x_valid_s   = 1'b1;
          flush_cnt_s = flush_inc_s;
          if (flush_inc_s >= FLUSH_END) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_FLUSH;
          end
        end else begin
          state_s = ST_FLUSH;
        end
      end
      default: begin
        state_s = ST_IDLE;
        x_in_s  = 18'sd0;
      end
    endcase
    if (state_s == ST_IDLE) begin
      stop_pending_s = 1'b0;
      flush_cnt_s    = {FW{1'b0}};
    end else begin
      stop_pending_s = stop_pending_s;
    end
  end

  // FIFO pointer/occupancy update; no bypass, so an empty pop never sees the pushed word
  always_comb begin
    wr_ptr_s = wr_ptr_r;
    rd_ptr_s = rd_ptr_r;
    count_s  = count_r;
    if (state_s == ST_IDLE) begin
      wr_ptr_s = {AW{1'b0}};
      rd_ptr_s = {AW{1'b0}};
      count_s  = {(AW + 1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_s = wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_s = rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_s = rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_s = count_r + (AW + 1)'(1);
        2'b01:   count_s = count_r - (AW + 1)'(1);
        default: count_s = count_r;
      endcase
    end
  end

  // Registered handshake and status derived from the next state
  always_comb begin
    src_ready_s = (state_s == ST_STREAM) && (count_s < FULL_CNT) && !stop_pending_s;
    busy_s      = (state_s != ST_IDLE);
  end

  // State, control and output registers
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state_r         <= ST_IDLE;
      wr_ptr_r        <= {AW{1'b0}};
      rd_ptr_r        <= {AW{1'b0}};
      count_r         <= {(AW + 1){1'b0}};
      stop_pending_r  <= 1'b0;
      flush_cnt_r     <= {FW{1'b0}};
      x_in_r          <= 18'sd0;
      x_valid_r       <= 1'b0;
      src_ready_r     <= 1'b0;
      busy_r          <= 1'b0;
      underflow_cnt_r <= 8'd0;
    end else begin
      state_r         <= state_s;
      wr_ptr_r        <= wr_ptr_s;
      rd_ptr_r        <= rd_ptr_s;
      count_r         <= count_s;
      stop_pending_r  <= stop_pending_s;
      flush_cnt_r     <= flush_cnt_s;
      x_in_r          <= x_in_s;
      x_valid_r       <= x_valid_s;
      src_ready_r     <= src_ready_s;
      busy_r          <= busy_s;
      underflow_cnt_r <= underflow_cnt_s;
    end
  end

  // Sample storage
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_mem_r[i] <= 18'sd0;
      end
    end else if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= src_data;
    end
  end

  assign src_ready     = src_ready_r;
  assign x_in          = x_in_r;
  assign x_valid       = x_valid_r;
  assign busy          = busy_r;
  assign underflow_cnt = underflow_cnt_r;

endmodule

// File: tb/tb_filter_input_sequencer.sv
// Directed self-checking bench for filter_input_sequencer: impulse, stream,
// underflow saturation, FIFO full, no-bypass and mid-run reset scenarios.
module tb_filter_input_sequencer;

  logic               sys_clk = 1'b0;
  logic               reset;
  logic               sam_clk_en;
  logic               start;
  logic               mode_sel;
  logic               stop;
  logic signed [17:0] src_data;
  logic               src_valid;
  logic               src_ready;
  logic signed [17:0] x_in;
  logic               x_valid;
  logic               busy;
  logic [7:0]         underflow_cnt;

  int total = 0;
  int bad   = 0;

  filter_input_sequencer dut (
    .sys_clk       (sys_clk),
    .reset         (reset),
    .sam_clk_en    (sam_clk_en),
    .start         (start),
    .mode_sel      (mode_sel),
    .stop          (stop),
    .src_data      (src_data),
    .src_valid     (src_valid),
    .src_ready     (src_ready),
    .x_in          (x_in),
    .x_valid       (x_valid),
    .busy          (busy),
    .underflow_cnt (underflow_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One strobe cycle followed by one quiet cycle; checks the emitted sample
  task automatic strobe_chk(input string tag, input logic signed [31:0] exp);
    sam_clk_en = 1'b1;
    tick();
    sam_clk_en = 1'b0;
    check({tag, "_x"}, x_in, exp);
    check({tag, "_v"}, x_valid, 1);
    tick();
    check({tag, "_v0"}, x_valid, 0);
  endtask

  initial begin
    int pulses;
    reset = 1'b0; sam_clk_en = 1'b0; start = 1'b0; mode_sel = 1'b0;
    stop = 1'b0; src_data = 18'sd0; src_valid = 1'b0;

    // reset state, including strobes and start held while in reset
    #3;
    check("rst_x", x_in, 0);
    check("rst_v", x_valid, 0);
    check("rst_rdy", src_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_unf", underflow_cnt, 0);
    sam_clk_en = 1'b1; start = 1'b1;
    tick(); tick();
    check("rst_hold_v", x_valid, 0);
    check("rst_hold_busy", busy, 0);
    sam_clk_en = 1'b0; start = 1'b0;
    reset = 1'b1;
    tick();
    check("idle_busy", busy, 0);

    // impulse run with a stray start during the flush
    mode_sel = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    check("imp_busy", busy, 1);
    check("imp_v0", x_valid, 0);
    pulses = 0;
    for (int k = 1; k <= 65; k++) begin
      sam_clk_en = 1'b1;
      tick();
      sam_clk_en = 1'b0;
      if (x_valid) pulses++;
      check("imp_x", x_in, (k == 1) ? 131071 : 0);
      check("imp_busy_k", busy, (k == 65) ? 0 : 1);
      for (int g = 0; g < 3; g++) begin
        if (k == 10 && g == 0) begin
          start = 1'b1; mode_sel = 1'b0;
        end
        tick();
        start = 1'b0;
        if (x_valid) pulses++;
      end
    end
    check("imp_pulses", pulses, 65);
    check("imp_idle_x", x_in, 0);

    // stream 100, -200, 300 then stop; start coincides with a strobe
    mode_sel = 1'b0; start = 1'b1; sam_clk_en = 1'b1;
    tick();
    start = 1'b0; sam_clk_en = 1'b0;
    check("str_start_v", x_valid, 0);
    check("str_start_x", x_in, 0);
    check("str_rdy", src_ready, 1);
    src_valid = 1'b1; src_data = 18'sd100;  tick();
    src_data = -18'sd200; tick();
    src_data = 18'sd300;  tick();
    src_valid = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0;
    check("str_rdy_stop", src_ready, 0);
    strobe_chk("str_s1", 100);
    strobe_chk("str_s2", -200);
    strobe_chk("str_s3", 300);
    for (int k = 1; k <= 64; k++) begin
      sam_clk_en = 1'b1;
      tick();
      sam_clk_en = 1'b0;
      check("str_zero", x_in, 0);
      check("str_busy", busy, (k == 64) ? 0 : 1);
      tick();
    end
    check("str_unf", underflow_cnt, 0);

    // underflow counting and saturation
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 10; k++) strobe_chk("unf_x", 0);
    check("unf_10", underflow_cnt, 10);
    for (int k = 0; k < 290; k++) begin
      sam_clk_en = 1'b1; tick(); sam_clk_en = 1'b0; tick();
    end
    check("unf_sat", underflow_cnt, 255);
    stop = 1'b1; tick(); stop = 1'b0;
    strobe_chk("unf_stop", 0);
    check("unf_stop_cnt", underflow_cnt, 255);
    for (int k = 0; k < 63; k++) begin
      sam_clk_en = 1'b1; tick(); sam_clk_en = 1'b0; tick();
    end
    check("unf_done_busy", busy, 0);

    // start clears the counter; push+pop on an empty FIFO is an underflow
    start = 1'b1; tick(); start = 1'b0;
    check("clr_unf", underflow_cnt, 0);
    src_valid = 1'b1; src_data = 18'sd55; sam_clk_en = 1'b1;
    tick();
    src_valid = 1'b0; sam_clk_en = 1'b0;
    check("byp_x", x_in, 0);
    check("byp_unf", underflow_cnt, 1);
    tick();
    strobe_chk("byp_pop", 55);
    check("byp_unf2", underflow_cnt, 1);

    // fill to full with src_valid held, then one strobe frees a slot
    src_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      src_data = 18'(10 + i);
      tick();
    end
    check("full_rdy", src_ready, 0);
    src_data = 18'sd14;
    tick(); tick();
    check("full_rdy_hold", src_ready, 0);
    sam_clk_en = 1'b1;
    tick();
    sam_clk_en = 1'b0;
    check("full_pop_x", x_in, 10);
    check("full_rdy_after", src_ready, 1);
    tick();
    src_valid = 1'b0;
    check("full_again", src_ready, 0);
    strobe_chk("full_s11", 11);
    strobe_chk("full_s12", 12);
    strobe_chk("full_s13", 13);
    strobe_chk("full_s14", 14);

    // reset mid-stream with three words queued
    src_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      src_data = 18'(21 + i);
      tick();
    end
    src_valid = 1'b0;
    check("mid_busy_pre", busy, 1);
    #2 reset = 1'b0;
    #1;
    check("mid_x", x_in, 0);
    check("mid_v", x_valid, 0);
    check("mid_rdy", src_ready, 0);
    check("mid_busy", busy, 0);
    check("mid_unf", underflow_cnt, 0);
    sam_clk_en = 1'b1;
    tick();
    sam_clk_en = 1'b0;
    check("mid_hold_v", x_valid, 0);
    reset = 1'b1;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    strobe_chk("post_rst", 0);
    check("post_rst_unf", underflow_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
